// File: rtl/zic_mmr_access_arb.sv
// Two-port (core / debug) round-robin arbiter for single-beat MMR accesses.
// Optional address map check enabled by defining ZIC_MMR_ADDR_CHK_EN.
module zic_mmr_access_arb #(
    parameter logic [15:0] ACK_ADDR = 16'h0804
) (
    input  logic        clk_i,
    input  logic        rst_n_i,

    input  logic        core_req_valid_i,
    output logic        core_req_ready_o,
    input  logic        core_req_we_i,
    input  logic [15:0] core_req_addr_i,
    input  logic [31:0] core_req_wdata_i,
    output logic        core_rsp_valid_o,
    input  logic        core_rsp_ready_i,
    output logic [31:0] core_rsp_rdata_o,
    output logic        core_rsp_err_o,

    input  logic        dbg_req_valid_i,
    output logic        dbg_req_ready_o,
    input  logic        dbg_req_we_i,
    input  logic [15:0] dbg_req_addr_i,
    input  logic [31:0] dbg_req_wdata_i,
    output logic        dbg_rsp_valid_o,
    input  logic        dbg_rsp_ready_i,
    output logic [31:0] dbg_rsp_rdata_o,
    output logic        dbg_rsp_err_o,

    output logic        mmr_read_en_o,
    output logic [15:0] mmr_read_addr_o,
    input  logic [31:0] mmr_read_data_i,
    output logic        mmr_write_en_o,
    output logic [15:0] mmr_write_addr_o,
    output logic [31:0] mmr_write_data_o,

    output logic        zic_ack_read_valid_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_last;     // 1: debug port was served last
    logic        r_src;      // 0: core, 1: debug
    logic        r_we;
    logic [15:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;

    logic        w_gnt_core;
    logic        w_gnt_dbg;
    logic        w_accept;
    logic        w_mapped;

`ifdef ZIC_MMR_ADDR_CHK_EN
    logic        r_err;

    function automatic logic addr_mapped(input logic [15:0] a);
        case (a)
            16'h0000, 16'h0004, 16'h0800, 16'h0804,
            16'h0808, 16'h080C, 16'h0810, 16'h0814: addr_mapped = 1'b1;
            default: addr_mapped = (a >= 16'h1000) && (a <= 16'h10BF);
        endcase
    endfunction

    assign w_mapped = addr_mapped(r_addr);
`else
    assign w_mapped       = 1'b1;
    assign core_rsp_err_o = 1'b0;
    assign dbg_rsp_err_o  = 1'b0;
`endif

    // A lone requester wins outright; contention goes to the port not served last.
    assign w_gnt_core = core_req_valid_i & (~dbg_req_valid_i | r_last);
    assign w_gnt_dbg  = dbg_req_valid_i  & (~core_req_valid_i | ~r_last);
    assign w_accept   = (r_state == IDLE) & (w_gnt_core | w_gnt_dbg);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_last  <= 1'b1;
            r_src   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
`ifdef ZIC_MMR_ADDR_CHK_EN
            r_err   <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_last  <= w_gnt_dbg;
                r_src   <= w_gnt_dbg;
                r_we    <= w_gnt_dbg ? dbg_req_we_i    : core_req_we_i;
                r_addr  <= w_gnt_dbg ? dbg_req_addr_i  : core_req_addr_i;
                r_wdata <= w_gnt_dbg ? dbg_req_wdata_i : core_req_wdata_i;
            end
            if (r_state == ISSUE) begin
                r_rdata <= (!r_we && w_mapped) ? mmr_read_data_i : '0;
`ifdef ZIC_MMR_ADDR_CHK_EN
                r_err   <= ~w_mapped;
`endif
            end
        end
    end

    always_comb begin
        w_state_nxt          = r_state;
        core_req_ready_o     = 1'b0;
        dbg_req_ready_o      = 1'b0;
        core_rsp_valid_o     = 1'b0;
        dbg_rsp_valid_o      = 1'b0;
        core_rsp_rdata_o     = '0;
        dbg_rsp_rdata_o      = '0;
`ifdef ZIC_MMR_ADDR_CHK_EN
        core_rsp_err_o       = 1'b0;
        dbg_rsp_err_o        = 1'b0;
`endif
        mmr_read_en_o        = 1'b0;
        mmr_read_addr_o      = '0;
        mmr_write_en_o       = 1'b0;
        mmr_write_addr_o     = '0;
        mmr_write_data_o     = '0;
        zic_ack_read_valid_o = 1'b0;

        case (r_state)
            IDLE: begin
                core_req_ready_o = w_gnt_core;
                dbg_req_ready_o  = w_gnt_dbg;
                if (w_accept) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (w_mapped) begin
                    if (r_we) begin
                        mmr_write_en_o   = 1'b1;
                        mmr_write_addr_o = r_addr;
                        mmr_write_data_o = r_wdata;
                    end else begin
                        mmr_read_en_o        = 1'b1;
                        mmr_read_addr_o      = r_addr;
                        zic_ack_read_valid_o = ~r_src & (r_addr == ACK_ADDR);
                    end
                end
                w_state_nxt = RESP;
            end
            RESP: begin
                if (!r_src) begin
                    core_rsp_valid_o = 1'b1;
                    core_rsp_rdata_o = r_rdata;
`ifdef ZIC_MMR_ADDR_CHK_EN
                    core_rsp_err_o   = r_err;
`endif
                    if (core_rsp_ready_i) begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    dbg_rsp_valid_o = 1'b1;
                    dbg_rsp_rdata_o = r_rdata;
`ifdef ZIC_MMR_ADDR_CHK_EN
                    dbg_rsp_err_o   = r_err;
`endif
                    if (dbg_rsp_ready_i) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: doc/zic_mmr_access_arb.md
ZIC_MMR_ACCESS_ARB -- requirements
Module: zic_mmr_access_arb

Interface
REQ-001 SHALL have parameter ACK_ADDR, default 16'h0804, the ACK register address whose core read claims an interrupt.
REQ-002 SHALL have port clk_i, input, 1, the single clock.
REQ-003 SHALL have port rst_n_i, input, 1, the asynchronous active-low reset.
REQ-004 SHALL have ports core_req_valid_i / dbg_req_valid_i, input, 1 each, access request from the core (port 0) and the debug port (port 1).
REQ-005 SHALL have ports core_req_ready_o / dbg_req_ready_o, output, 1 each, request accepted.
REQ-006 SHALL have ports core_req_we_i / dbg_req_we_i, input, 1 each, 1 = write, 0 = read.
REQ-007 SHALL have ports core_req_addr_i / dbg_req_addr_i, input, 16 each, MMR byte address.
REQ-008 SHALL have ports core_req_wdata_i / dbg_req_wdata_i, input, 32 each, write data.
REQ-009 SHALL have ports core_rsp_valid_o / dbg_rsp_valid_o, output, 1 each, response available.
REQ-010 SHALL have ports core_rsp_ready_i / dbg_rsp_ready_i, input, 1 each, response consumed.
REQ-011 SHALL have ports core_rsp_rdata_o / dbg_rsp_rdata_o, output, 32 each, read data (0 for writes).
REQ-012 SHALL have ports core_rsp_err_o / dbg_rsp_err_o, output, 1 each, unmapped-address error.
REQ-013 SHALL have ports mmr_read_en_o (output, 1) and mmr_read_addr_o (output, 16), driving the MMR read mux.
REQ-014 SHALL have port mmr_read_data_i, input, 32, MMR read mux data.
REQ-015 SHALL have ports mmr_write_en_o (output, 1), mmr_write_addr_o (output, 16) and mmr_write_data_o (output, 32), the MMR write strobe, address and data.
REQ-016 SHALL have port zic_ack_read_valid_o, output, 1, interrupt-claim qualifier to the MMR output mux.

Function
REQ-017 SHALL use the FSM states IDLE, ISSUE and RESP.
REQ-018 SHALL drive req_ready_o of the granted port high only in IDLE, combinationally from grant; the non-granted port's ready SHALL be 0.
REQ-019 Grant SHALL be round-robin: with both valid, the port not served last wins; the port served last is port 1 after reset (core first).
REQ-020 A single valid port SHALL be granted immediately, regardless of the round-robin pointer.
REQ-021 On accept (valid & ready) the block SHALL latch we, addr, wdata and source, update the round-robin pointer, and go IDLE->ISSUE.
REQ-022 In ISSUE, for exactly one cycle, the block SHALL drive mmr_read_en_o (read) or mmr_write_en_o (write) with the latched address/data, then go to RESP.
REQ-023 On a read, the block SHALL register mmr_read_data_i into the response data at the clock edge ending ISSUE; on a write, response data SHALL be 0.
REQ-024 zic_ack_read_valid_o SHALL be 1 only in ISSUE, for a core read of ACK_ADDR; a debug read of ACK_ADDR SHALL NOT assert it.
REQ-025 In RESP, the source's rsp_valid_o SHALL hold with stable rdata/err until rsp_ready_i is 1, then go RESP->IDLE; the other port's rsp_valid_o SHALL stay 0.
REQ-026 Latency SHALL be accept edge -> ISSUE (1 cycle) -> rsp_valid_o in the next cycle; minimum occupancy is 3 cycles per access.
REQ-027 rsp_ready_i without rsp_valid_o, and req_valid_i outside IDLE, SHALL be ignored.
REQ-028 mmr_*_addr_o and mmr_write_data_o SHALL be 0 whenever their enable is 0.

Reset
REQ-029 Asynchronous assertion of rst_n_i SHALL force IDLE, round-robin pointer = port 1, and all outputs and data registers to 0, including mid-ISSUE or mid-RESP.
REQ-030 An access in flight at reset SHALL be dropped with no response, and no strobe SHALL be issued after reset release until a new accept.

Configuration
REQ-031 Macro ZIC_MMR_ADDR_CHK_EN defined: only addresses 0x0000, 0x0004, 0x0800, 0x0804, 0x0808, 0x080C, 0x0810, 0x0814 and 0x1000-0x10BF SHALL be mapped.
REQ-032 With ZIC_MMR_ADDR_CHK_EN defined, an unmapped access SHALL spend ISSUE with no strobe and no ack qualifier, and respond with rdata 0 and err 1.
REQ-033 Macro ZIC_MMR_ADDR_CHK_EN undefined: all accesses SHALL be issued and rsp_err_o SHALL be constant 0.

Verification
REQ-034 Core read 0x0004 with mmr_read_data_i=32'hDEAD_BEEF -> mmr_read_en_o 1 for one cycle; core_rsp_valid_o two cycles after accept with rdata DEADBEEF and err 0.
REQ-035 Both ports request continuously after reset -> grants alternate core, dbg, core, dbg; each rsp_valid only on its own port.
REQ-036 Core read 0x0804, then dbg read 0x0804 -> zic_ack_read_valid_o pulses one cycle for the core read only.
REQ-037 Dbg write 0x1004 data 32'h0000_00A5 -> mmr_write_en_o one cycle with addr 0x1004 and data A5; response rdata 0; with rsp_ready_i held 0 for 5 cycles, rsp_valid stays high, then completes.
REQ-038 rst_n_i pulsed low during ISSUE -> all outputs 0 immediately and no response; with ZIC_MMR_ADDR_CHK_EN defined, a read of 0x2000 -> no strobe, err 1, rdata 0.
